// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams 32-bit program words big-endian into a byte array, one byte per cycle.
// Optional LOADER_CHECKSUM_EN adds a running 32-bit sum of written words.
module instr_mem_loader #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [BITS_DATA-1:0] wr_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic                 wr_last,
    input  logic [BITS_ADDR-1:0] A,
    output logic [BITS_DATA-1:0] RD,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
`ifdef LOADER_CHECKSUM_EN
    output logic [BITS_DATA-1:0] checksum,
`endif
    output logic [BITS_ADDR-2:0] word_count
);
    localparam int DEPTH = 2 ** BITS_ADDR;
    typedef enum logic [2:0] {IDLE, WAIT, WR0, WR1, WR2, WR3, DONE} state_t;
    state_t state, state_nx;
    // One extra bit so a completely full array (ptr == DEPTH) is distinguishable from empty
    logic [BITS_ADDR:0]   ptr;
    logic [BITS_DATA-1:0] hold;
    logic                 hold_last;
    logic [7:0]           mem [DEPTH];
    logic                 accept, full, restart, writing;
    logic [7:0]           byte_w;
    assign accept  = (state == WAIT) && wr_valid;
    assign full    = ptr > (BITS_ADDR + 1)'(DEPTH - 4);
    assign restart = start && (state == IDLE || state == DONE);
    assign writing = (state == WR0) || (state == WR1) || (state == WR2) || (state == WR3);
    assign byte_w  = state == WR0 ? hold[31:24] :
                     state == WR1 ? hold[23:16] :
                     state == WR2 ? hold[15:8]  : hold[7:0];
    always_comb begin
        state_nx = state;
        wr_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: state_nx = start ? WAIT : IDLE;
            WAIT: begin
                wr_ready = 1'b1;
                busy     = 1'b1;
                state_nx = !wr_valid ? WAIT : full ? DONE : WR0;
            end
            WR0: begin
                busy     = 1'b1;
                state_nx = WR1;
            end
            WR1: begin
                busy     = 1'b1;
                state_nx = WR2;
            end
            WR2: begin
                busy     = 1'b1;
                state_nx = WR3;
            end
            WR3: begin
                busy     = 1'b1;
                state_nx = hold_last ? DONE : WAIT;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = start ? WAIT : DONE;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
            hold       <= '0;
            hold_last  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            if (restart) begin
                ptr        <= '0;
                word_count <= '0;
                overflow   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                checksum   <= '0;
`endif
            end
            if (accept && full) overflow <= 1'b1;
            if (accept && !full) begin
                hold      <= wr_data;
                hold_last <= wr_last;
            end
            if (writing) ptr <= ptr + 1'b1;
            if (state == WR3) begin
                word_count <= word_count + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                checksum   <= checksum + hold;
`endif
            end
        end
    end
    // Memory is deliberately outside the reset domain so a reset never erases a loaded program
    always_ff @(posedge clk) begin
        if (writing) mem[ptr[BITS_ADDR-1:0]] <= byte_w;
    end
    assign RD = {mem[A], mem[A + BITS_ADDR'(1)], mem[A + BITS_ADDR'(2)], mem[A + BITS_ADDR'(3)]};
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed, table-driven checks of the instruction memory loader.
module tb_instr_mem_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_last = 1'b0;
    logic [6:0]  A = '0;
    logic        wr_ready, busy, done, overflow;
    logic [31:0] RD;
    logic [5:0]  word_count;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_q[$];

    instr_mem_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_last(wr_last), .A(A), .RD(RD), .busy(busy), .done(done),
        .overflow(overflow),
`ifdef LOADER_CHECKSUM_EN
        .checksum(checksum),
`endif
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_valid && wr_ready) acc_q.push_back(cyc);
        cyc++;
    end

    typedef struct {
        logic [6:0]  a;
        logic [31:0] rd;
    } vec_t;
    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic read_chk(input string name, input logic [6:0] a, input logic [31:0] exp);
        A = a;
        #1;
        chk(name, RD, exp);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge, wr_valid still high
    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        wr_data  = d;
        wr_last  = l;
        wr_valid = 1'b1;
        while (!wr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) chk("send_timeout", 32'(wr_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        int n;
        vt[0] = '{7'd0, 32'hDEADBEEF};
        vt[1] = '{7'd4, 32'h00000013};
        vt[2] = '{7'd8, 32'hCAFEF00D};
        vt[3] = '{7'd1, 32'hADBEEF00};
        vt[4] = '{7'd2, 32'hBEEF0000};
        vt[5] = '{7'd3, 32'hEF000000};
        vt[6] = '{7'd6, 32'h0013CAFE};

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_wc", 32'(word_count), 32'd0);
        rst_n = 1'b1;

        pulse_start();
        chk("wait_ready", 32'(wr_ready), 32'd1);
        chk("wait_busy", 32'(busy), 32'd1);
        send(32'h12345678, 1'b1);
        wr_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            if (!wr_ready) n++;
            @(negedge clk);
        end
        chk("ready_low_cycles", 32'(n), 32'd4);
        chk("w1_done", 32'(done), 32'd1);
        chk("w1_busy", 32'(busy), 32'd0);
        chk("w1_wc", 32'(word_count), 32'd1);
        chk("w1_overflow", 32'(overflow), 32'd0);
        read_chk("w1_rd", 7'd0, 32'h12345678);

        pulse_start();
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_wc", 32'(word_count), 32'd0);
        acc_q.delete();
        send(32'hDEADBEEF, 1'b0);
        send(32'h00000013, 1'b0);
        send(32'hCAFEF00D, 1'b1);
        wr_valid = 1'b0;
        wait_done();
        chk("w3_wc", 32'(word_count), 32'd3);
        chk("accepts", 32'(acc_q.size()), 32'd3);
        if (acc_q.size() == 3) begin
            chk("gap01", 32'(acc_q[1] - acc_q[0]), 32'd5);
            chk("gap12", 32'(acc_q[2] - acc_q[1]), 32'd5);
        end
        for (int i = 0; i < 7; i++) read_chk($sformatf("tbl_a%0d", vt[i].a), vt[i].a, vt[i].rd);

        pulse_start();
        for (int i = 0; i < 33; i++)
            send(i == 0 ? 32'hCCDD0000 : i == 31 ? 32'h1111AABB : i == 32 ? 32'hFFFFFFFF : {4{8'(i)}},
                 i == 32);
        wr_valid = 1'b0;
        wait_done();
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_done", 32'(done), 32'd1);
        chk("ovf_wc", 32'(word_count), 32'd32);
        read_chk("ovf_mem0", 7'd0, 32'hCCDD0000);
        read_chk("ovf_mem124", 7'd124, 32'h1111AABB);
        read_chk("wrap_rd", 7'd126, 32'hAABBCCDD);

        pulse_start();
        chk("restart_ovf", 32'(overflow), 32'd0);
        send(32'h11223344, 1'b0);
        wr_valid = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ign_busy", 32'(busy), 32'd1);
        n = 0;
        while (!wr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("start_ign_ready", 32'(wr_ready), 32'd1);
        chk("start_ign_wc", 32'(word_count), 32'd1);
        read_chk("start_ign_rd", 7'd0, 32'h11223344);
        send(32'h55667788, 1'b0);
        wr_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_wc", 32'(word_count), 32'd0);
        chk("mid_rst_ready", 32'(wr_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        read_chk("mid_rst_mem", 7'd4, 32'h55660101);

`ifdef LOADER_CHECKSUM_EN
        pulse_start();
        send(32'hFFFFFFFF, 1'b0);
        send(32'h00000002, 1'b1);
        wr_valid = 1'b0;
        wait_done();
        chk("checksum", checksum, 32'h00000001);
        pulse_start();
        chk("checksum_clr", checksum, 32'h00000000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
